rob_core: RTL and testbench

- Reorder buffer for the Tomasulo RISC-V core, directly upstream of the rename register file.
- Allocates ROB tags at issue and captures results from the CDB.
- Answers operand-readiness queries from the reservation stations.
- Retires entries strictly in program order, supplying the commit stream (entry, destination, result) the register file consumes.
- Flushes on a mispredicted branch.

---
 rtl/rob_core.sv | 159 +++++++++++++++
 tb/tb_rob_core.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_core.sv
// ============================================================================
//  Module      : rob_core
//  Description : Reorder buffer. Allocates tags at issue, captures CDB
//                results, answers operand queries, retires in program order
//                and flushes on a mispredicted branch.
//                Optional: ROB_CDB_BYPASS_EN forwards a same-cycle CDB
//                broadcast to the operand query ports.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_core #(
    parameter int         IDX_W    = 4,
    parameter int         TAG_W    = IDX_W + 1,
    parameter logic [5:0] NULL_REG = 6'd32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             issue_sgn,
    input  logic [5:0]       issue_rd,
    output logic [TAG_W-1:0] rob_new_entry,
    output logic             rob_full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_entry,
    input  logic [31:0]      cdb_value,
    input  logic             cdb_mispredict,
    input  logic [31:0]      cdb_target,
    input  logic [TAG_W-1:0] qj_entry,
    input  logic [TAG_W-1:0] qk_entry,
    output logic             qj_ready,
    output logic [31:0]      qj_value,
    output logic             qk_ready,
    output logic [31:0]      qk_value,
    output logic             commit_sgn,
    output logic [TAG_W-1:0] rob_entry,
    output logic [5:0]       rob_des,
    output logic [31:0]      rob_result,
    output logic             flush,
    output logic [31:0]      flush_pc
);

    localparam int               DEPTH      = 1 << IDX_W;
    localparam logic [TAG_W-1:0] c_NULL_TAG = {1'b1, {IDX_W{1'b0}}};
    localparam logic [IDX_W:0]   c_FULL_CNT = {1'b1, {IDX_W{1'b0}}};

    logic             r_busy   [DEPTH];
    logic             r_ready  [DEPTH];
    logic [5:0]       r_rd     [DEPTH];
    logic [31:0]      r_value  [DEPTH];
    logic             r_misp   [DEPTH];
    logic [31:0]      r_target [DEPTH];
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [IDX_W:0]   r_count;

    logic             w_full;
    logic             w_do_issue;
    logic             w_commit;
    logic             w_flush;
    logic             w_cdb_hit;
    logic [IDX_W-1:0] w_cdb_idx;
    logic [IDX_W-1:0] w_qj_idx;
    logic [IDX_W-1:0] w_qk_idx;

    assign w_full        = (r_count == c_FULL_CNT);
    assign w_do_issue    = issue_sgn && !w_full;
    assign w_commit      = r_busy[r_head] && r_ready[r_head];
    assign w_flush       = w_commit && r_misp[r_head];
    assign w_cdb_idx     = cdb_entry[IDX_W-1:0];
    assign w_cdb_hit     = cdb_valid && !cdb_entry[IDX_W] && r_busy[w_cdb_idx];
    assign w_qj_idx      = qj_entry[IDX_W-1:0];
    assign w_qk_idx      = qk_entry[IDX_W-1:0];
    assign rob_new_entry = {1'b0, r_tail};
    assign rob_full      = w_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_busy[i]   <= 1'b0;
                r_ready[i]  <= 1'b0;
                r_rd[i]     <= NULL_REG;
                r_value[i]  <= 32'd0;
                r_misp[i]   <= 1'b0;
                r_target[i] <= 32'd0;
            end
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            commit_sgn <= 1'b0;
            rob_entry  <= c_NULL_TAG;
            rob_des    <= NULL_REG;
            rob_result <= 32'd0;
            flush      <= 1'b0;
            flush_pc   <= 32'd0;
        end else if (!rdy) begin
            commit_sgn <= 1'b0;
            flush      <= 1'b0;
        end else begin
            if (w_cdb_hit) begin
                r_ready[w_cdb_idx]  <= 1'b1;
                r_value[w_cdb_idx]  <= cdb_value;
                r_misp[w_cdb_idx]   <= cdb_mispredict;
                r_target[w_cdb_idx] <= cdb_target;
            end
            if (w_do_issue) begin
                r_busy[r_tail]  <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_rd[r_tail]    <= issue_rd;
                r_misp[r_tail]  <= 1'b0;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_commit) begin
                r_busy[r_head] <= 1'b0;
                r_head         <= r_head + 1'b1;
                rob_entry      <= {1'b0, r_head};
                rob_des        <= r_rd[r_head];
                rob_result     <= r_value[r_head];
            end
            case ({w_do_issue, w_commit})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            commit_sgn <= w_commit;
            flush      <= w_flush;
            // A flush wins over every other update on the same edge, including the issue.
            if (w_flush) begin
                flush_pc <= r_target[r_head];
                for (int i = 0; i < DEPTH; i++) begin
                    r_busy[i] <= 1'b0;
                end
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end
        end
    end

    always_comb begin
        qj_ready = !qj_entry[IDX_W] && r_busy[w_qj_idx] && r_ready[w_qj_idx];
        qj_value = qj_ready ? r_value[w_qj_idx] : 32'd0;
        qk_ready = !qk_entry[IDX_W] && r_busy[w_qk_idx] && r_ready[w_qk_idx];
        qk_value = qk_ready ? r_value[w_qk_idx] : 32'd0;
`ifdef ROB_CDB_BYPASS_EN
        if (w_cdb_hit && (qj_entry == cdb_entry)) begin
            qj_ready = 1'b1;
            qj_value = cdb_value;
        end
        if (w_cdb_hit && (qk_entry == cdb_entry)) begin
            qk_ready = 1'b1;
            qk_value = cdb_value;
        end
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_rob_core.sv
// ============================================================================
//  Module      : tb_rob_core
//  Description : Self-checking bench for rob_core with a commit scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rob_core;

    logic        clk = 1'b0;
    logic        rst, rdy, issue_sgn, cdb_valid, cdb_mispredict;
    logic [5:0]  issue_rd;
    logic [4:0]  cdb_entry, qj_entry, qk_entry;
    logic [31:0] cdb_value, cdb_target;
    logic [4:0]  rob_new_entry, rob_entry;
    logic        rob_full, qj_ready, qk_ready, commit_sgn, flush;
    logic [31:0] qj_value, qk_value, rob_result, flush_pc;
    logic [5:0]  rob_des;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0]  entry;
        logic [5:0]  des;
        logic [31:0] res;
        logic        fl;
        logic [31:0] fpc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    rob_core dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_sgn(issue_sgn), .issue_rd(issue_rd),
        .rob_new_entry(rob_new_entry), .rob_full(rob_full),
        .cdb_valid(cdb_valid), .cdb_entry(cdb_entry), .cdb_value(cdb_value),
        .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
        .qj_entry(qj_entry), .qk_entry(qk_entry),
        .qj_ready(qj_ready), .qj_value(qj_value),
        .qk_ready(qk_ready), .qk_value(qk_value),
        .commit_sgn(commit_sgn), .rob_entry(rob_entry), .rob_des(rob_des),
        .rob_result(rob_result), .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    // Scoreboard: every commit pulse pops and checks the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (commit_sgn) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL commit_unexpected: got entry=%0d des=%0d res=%h, required no commit",
                             rob_entry, rob_des, rob_result);
                end else begin
                    mon_e = sb.pop_front();
                    if ({rob_entry, rob_des, rob_result, flush} !== {mon_e.entry, mon_e.des, mon_e.res, mon_e.fl}
                        || (mon_e.fl && flush_pc !== mon_e.fpc)) begin
                        failures++;
                        $display("FAIL commit_data: got entry=%0d des=%0d res=%h flush=%b pc=%h, required entry=%0d des=%0d res=%h flush=%b pc=%h",
                                 rob_entry, rob_des, rob_result, flush, flush_pc,
                                 mon_e.entry, mon_e.des, mon_e.res, mon_e.fl, mon_e.fpc);
                    end
                end
            end else if (flush !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL flush_without_commit: got flush=%b, required 0", flush);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1; rdy = 1'b1; issue_sgn = 1'b0; issue_rd = 6'd0;
        cdb_valid = 1'b0; cdb_entry = 5'd16; cdb_value = 32'd0;
        cdb_mispredict = 1'b0; cdb_target = 32'd0;
        qj_entry = 5'd16; qk_entry = 5'd16;
        tick; tick;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic issue(input logic [5:0] rd);
        issue_sgn = 1'b1; issue_rd = rd;
        tick;
        issue_sgn = 1'b0;
    endtask

    task automatic cdb(input logic [4:0] tag, input logic [31:0] val,
                       input logic misp, input logic [31:0] tgt);
        cdb_valid = 1'b1; cdb_entry = tag; cdb_value = val;
        cdb_mispredict = misp; cdb_target = tgt;
    endtask

    task automatic cdb_off;
        cdb_valid = 1'b0; cdb_mispredict = 1'b0; cdb_entry = 5'd16;
    endtask

    task automatic test_reset;
        apply_reset;
        checks++;
        if ({commit_sgn, flush, rob_entry, rob_des, rob_result, flush_pc, rob_new_entry, rob_full, qj_ready, qj_value}
            !== {1'b0, 1'b0, 5'd16, 6'd32, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL reset_state: got commit=%b flush=%b entry=%0d des=%0d res=%h pc=%h tail=%0d full=%b",
                     commit_sgn, flush, rob_entry, rob_des, rob_result, flush_pc, rob_new_entry, rob_full);
        end
    endtask

    task automatic test_fill;
        apply_reset;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rob_new_entry !== 5'(i) || rob_full !== 1'b0) begin
                failures++;
                $display("FAIL fill_tail: got tail=%0d full=%b, required tail=%0d full=0", rob_new_entry, rob_full, i);
            end
            issue(6'(i + 1));
        end
        checks++;
        if (rob_new_entry !== 5'd0 || rob_full !== 1'b1) begin
            failures++;
            $display("FAIL fill_full: got tail=%0d full=%b, required tail=0 full=1", rob_new_entry, rob_full);
        end
        issue(6'd17);
        checks++;
        if (rob_new_entry !== 5'd0 || rob_full !== 1'b1) begin
            failures++;
            $display("FAIL issue_when_full: got tail=%0d full=%b, required tail=0 full=1", rob_new_entry, rob_full);
        end
    endtask

    task automatic test_single_commit;
        apply_reset;
        issue(6'd5);
        cdb(5'd0, 32'h1234, 1'b0, 32'd0);
        sb.push_back('{entry: 5'd0, des: 6'd5, res: 32'h1234, fl: 1'b0, fpc: 32'd0});
        tick;
        cdb_off;
        checks++;
        if (commit_sgn !== 1'b0) begin
            failures++;
            $display("FAIL commit_too_early: got commit=%b, required 0", commit_sgn);
        end
        tick;
        checks++;
        if (commit_sgn !== 1'b1 || rob_entry !== 5'd0 || rob_des !== 6'd5 || rob_result !== 32'h1234) begin
            failures++;
            $display("FAIL commit_latency: got commit=%b entry=%0d des=%0d res=%h, required 1 0 5 00001234",
                     commit_sgn, rob_entry, rob_des, rob_result);
        end
        tick;
        checks++;
        if (commit_sgn !== 1'b0) begin
            failures++;
            $display("FAIL commit_pulse: got commit=%b, required 0", commit_sgn);
        end
    endtask

    task automatic test_out_of_order;
        apply_reset;
        issue(6'd7);
        issue(6'd8);
        cdb(5'd1, 32'hB, 1'b0, 32'd0);
        tick;
        cdb(5'd0, 32'hA, 1'b0, 32'd0);
        sb.push_back('{entry: 5'd0, des: 6'd7, res: 32'hA, fl: 1'b0, fpc: 32'd0});
        sb.push_back('{entry: 5'd1, des: 6'd8, res: 32'hB, fl: 1'b0, fpc: 32'd0});
        tick;
        cdb_off;
        tick;
        checks++;
        if (commit_sgn !== 1'b1 || rob_entry !== 5'd0 || rob_result !== 32'hA) begin
            failures++;
            $display("FAIL ooo_first: got commit=%b entry=%0d res=%h, required 1 0 0000000a", commit_sgn, rob_entry, rob_result);
        end
        tick;
        checks++;
        if (commit_sgn !== 1'b1 || rob_entry !== 5'd1 || rob_result !== 32'hB) begin
            failures++;
            $display("FAIL ooo_second: got commit=%b entry=%0d res=%h, required 1 1 0000000b", commit_sgn, rob_entry, rob_result);
        end
        tick;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL ooo_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_mispredict;
        apply_reset;
        for (int i = 0; i < 4; i++) issue(6'(i + 1));
        cdb(5'd0, 32'h77, 1'b1, 32'h100);
        sb.push_back('{entry: 5'd0, des: 6'd1, res: 32'h77, fl: 1'b1, fpc: 32'h100});
        tick;
        cdb_off;
        issue_sgn = 1'b1; issue_rd = 6'd20;
        tick;
        issue_sgn = 1'b0;
        checks++;
        if (commit_sgn !== 1'b1 || flush !== 1'b1 || flush_pc !== 32'h100 || rob_new_entry !== 5'd0 || rob_full !== 1'b0) begin
            failures++;
            $display("FAIL mispredict_flush: got commit=%b flush=%b pc=%h tail=%0d full=%b, required 1 1 00000100 0 0",
                     commit_sgn, flush, flush_pc, rob_new_entry, rob_full);
        end
        cdb(5'd2, 32'h99, 1'b0, 32'd0);
        qj_entry = 5'd2;
        tick;
        cdb_off;
        checks++;
        if (flush !== 1'b0 || qj_ready !== 1'b0 || qj_value !== 32'd0) begin
            failures++;
            $display("FAIL late_cdb: got flush=%b qj_ready=%b qj_value=%h, required 0 0 0", flush, qj_ready, qj_value);
        end
        tick; tick;
    endtask

    task automatic test_freeze;
        apply_reset;
        issue(6'd3);
        cdb(5'd0, 32'h42, 1'b0, 32'd0);
        tick;
        cdb_off;
        rdy = 1'b0;
        issue_sgn = 1'b1; issue_rd = 6'd9;
        tick; tick;
        issue_sgn = 1'b0;
        checks++;
        if (commit_sgn !== 1'b0 || rob_new_entry !== 5'd1 || rob_entry !== 5'd16) begin
            failures++;
            $display("FAIL freeze_hold: got commit=%b tail=%0d entry=%0d, required 0 1 16", commit_sgn, rob_new_entry, rob_entry);
        end
        rdy = 1'b1;
        sb.push_back('{entry: 5'd0, des: 6'd3, res: 32'h42, fl: 1'b0, fpc: 32'd0});
        tick;
        checks++;
        if (commit_sgn !== 1'b1 || rob_entry !== 5'd0) begin
            failures++;
            $display("FAIL freeze_release: got commit=%b entry=%0d, required 1 0", commit_sgn, rob_entry);
        end
        tick;
    endtask

    task automatic test_query;
        logic        exp_rdy;
        logic [31:0] exp_val;
        apply_reset;
        for (int i = 0; i < 4; i++) issue(6'(i + 1));
        cdb(5'd3, 32'h55, 1'b0, 32'd0);
        qj_entry = 5'd3;
        qk_entry = 5'd16;
        #1;
`ifdef ROB_CDB_BYPASS_EN
        exp_rdy = 1'b1; exp_val = 32'h55;
`else
        exp_rdy = 1'b0; exp_val = 32'd0;
`endif
        checks++;
        if (qj_ready !== exp_rdy || qj_value !== exp_val) begin
            failures++;
            $display("FAIL query_same_cycle: got ready=%b value=%h, required %b %h", qj_ready, qj_value, exp_rdy, exp_val);
        end
        checks++;
        if (qk_ready !== 1'b0 || qk_value !== 32'd0) begin
            failures++;
            $display("FAIL query_null: got ready=%b value=%h, required 0 0", qk_ready, qk_value);
        end
        tick;
        cdb_off;
        qk_entry = 5'd1;
        #1;
        checks++;
        if (qj_ready !== 1'b1 || qj_value !== 32'h55 || qk_ready !== 1'b0 || qk_value !== 32'd0) begin
            failures++;
            $display("FAIL query_stored: got j=%b/%h k=%b/%h, required 1/00000055 0/00000000", qj_ready, qj_value, qk_ready, qk_value);
        end
    endtask

    task automatic test_back_to_back;
        int wait_cnt;
        apply_reset;
        for (int i = 0; i < 16; i++) issue(6'(i + 1));
        cdb(5'd0, 32'hA0, 1'b0, 32'd0);
        sb.push_back('{entry: 5'd0, des: 6'd1, res: 32'hA0, fl: 1'b0, fpc: 32'd0});
        tick;
        cdb_off;
        issue_sgn = 1'b1; issue_rd = 6'd40;
        tick;
        issue_sgn = 1'b0;
        checks++;
        if (rob_new_entry !== 5'd0 || rob_full !== 1'b0) begin
            failures++;
            $display("FAIL full_commit_issue: got tail=%0d full=%b, required 0 0", rob_new_entry, rob_full);
        end
        issue(6'd41);
        checks++;
        if (rob_new_entry !== 5'd1 || rob_full !== 1'b1) begin
            failures++;
            $display("FAIL refill: got tail=%0d full=%b, required 1 1", rob_new_entry, rob_full);
        end
        for (int t = 1; t <= 16; t++) begin
            cdb(5'(t % 16), 32'h100 + 32'(t), 1'b0, 32'd0);
            sb.push_back('{entry: 5'(t % 16), des: (t == 16) ? 6'd41 : 6'(t + 1),
                           res: 32'h100 + 32'(t), fl: 1'b0, fpc: 32'd0});
            tick;
        end
        cdb_off;
        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 40) begin
            tick;
            wait_cnt++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_drain: got %0d pending commits, required 0", sb.size());
        end
        checks++;
        if (rob_new_entry !== 5'd1 || rob_full !== 1'b0) begin
            failures++;
            $display("FAIL b2b_final: got tail=%0d full=%b, required 1 0", rob_new_entry, rob_full);
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_single_commit;
        test_out_of_order;
        test_mispredict;
        test_freeze;
        test_query;
        test_back_to_back;
        tick; tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
